hazard_stall_controller: RTL

- Pipeline control block for the 5-stage MIPS core. It sits beside the ID stage and generates per-stage write enables, flushes and an ID/EX bubble.
- It handles three events: a load-use hazard between ID and EX, a taken branch resolved in MEM, and a multi-cycle data-memory access in MEM that must freeze the whole pipeline.
- It also keeps saturating stall and flush counters for performance and debug.

---
 rtl/hazard_stall_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller for a 5-stage MIPS core: load-use stalls,
// taken-branch flushes, multi-cycle memory freezes with timeout, and perf counters.
module hazard_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instruction,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             mem_Branch_taken,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             idex_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       access, uses_rt, load_use, freeze;

  assign opcode = id_instruction[31:26];
  assign rs     = id_instruction[25:21];
  assign rt     = id_instruction[20:16];

  always_comb begin
    access   = mem_MemRead | mem_MemWrite;
    uses_rt  = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h2B);
    load_use = ex_MemRead && (ex_rt != 5'd0) &&
               ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    if (state_q == RUN) begin
      freeze = access & ~mem_ready;
    end else begin
      freeze = ~mem_ready & (wait_cnt_q != TIMEOUT_CNT);
    end
  end

  // Output priority: freeze > taken branch > load-use > normal advance.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    idex_bubble = 1'b0;
    if (rst || freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (mem_Branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (access && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d       = RUN;
          wait_cnt_d    = 8'd0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    flush_events_d = flush_events_q;
    if (ifid_flush && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule
